cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single line-wide physical memory path between the instruction cache and the data cache.
- Read-only I-cache and read/write D-cache requests are serialised onto one downstream port, which feeds the eviction write buffer / pmem interface.
- The downstream response and read data are routed back to the requester that owns the grant.
- Ties between simultaneous requests are resolved round-robin so neither requester starves.

Parameters:
ADDR_WIDTH, 32, byte address width of all ports
LINE_WIDTH, 256, cache line width in bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_read  in  1  I-cache line read request, level, held until i_resp
i_address  in  ADDR_WIDTH  I-cache line address
i_rdata  out  LINE_WIDTH  line data to I-cache, valid with i_resp
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, level
d_write  in  1  D-cache line write (writeback) request, level
d_address  in  ADDR_WIDTH  D-cache line address
d_wdata  in  LINE_WIDTH  D-cache writeback line
d_rdata  out  LINE_WIDTH  line data to D-cache, valid with d_resp
d_resp  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  downstream read request
mem_write  out  1  downstream write request
mem_address  out  ADDR_WIDTH  downstream address
mem_wdata  out  LINE_WIDTH  downstream write line
mem_rdata  in  LINE_WIDTH  downstream read line
mem_resp  in  1  downstream completion pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset:
  - One clock. Synchronous active-high rst.
  - On a rising clk with rst=1: state<=IDLE, last_grant<=I, latched address/wdata/op cleared to 0.
- Outputs in reset and in IDLE: mem_read=0, mem_write=0, i_resp=0, d_resp=0, busy=0, mem_address=0, mem_wdata=0.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - D pending only (d_read|d_write): latch d_address, d_wdata, op; go to SERVE_D.
  - I pending only: latch i_address; go to SERVE_I.
  - Both pending: grant the requester that is not last_grant.
  - On every grant, update last_grant.
- SERVE_I:
  - mem_read=1; mem_address=latched address.
  - On mem_resp: i_resp=1 and i_rdata=mem_rdata combinationally in the same cycle; next state DONE.
- SERVE_D:
  - If the latched op is write: mem_write=1 and mem_wdata=latched wdata.
  - Otherwise: mem_read=1.
  - On mem_resp: d_resp=1, d_rdata=mem_rdata; next state DONE.
- DONE:
  - One bubble cycle, all request/response outputs 0, busy=1; next state IDLE.
  - Prevents re-granting a request the cache has not yet deasserted after its resp.
- Latency:
  - A request first visible in IDLE at cycle N drives mem_read/mem_write at N+1.
  - mem_resp at cycle M produces the requester resp at M.
  - The next grant can be made at M+2 at the earliest, with mem_* asserted at M+3.
- Data steering:
  - i_rdata and d_rdata both carry mem_rdata continuously.
  - Only the resp pulse qualifies the data.
- Changes to address, wdata or requests during SERVE_* are ignored; the latched values drive mem_*.
- A request withdrawn mid-transaction does not cancel it. The downstream transaction completes and the resp pulse is still issued.
- d_read and d_write both high: treated as a write.
- mem_resp while in IDLE or DONE: ignored, no resp is generated.
- rst during SERVE_*:
  - mem_read/mem_write drop in the cycle after the reset edge.
  - A later mem_resp is ignored.
  - last_grant returns to I.
- No combinational path from any requester input to mem_read/mem_write. Both are decoded from state and the latched op only.

Test Plan:
- Reset, then i_read=1, i_address=0x0000_0040; mem_resp held 0 for 3 cycles, then pulsed with mem_rdata=0xA5 repeated → mem_read=1 with mem_address=0x40 from the cycle after the request; i_resp=1 with i_rdata=0xA5... in the mem_resp cycle; busy=1 in DONE; IDLE after that.
- d_write=1, d_address=0x100, d_wdata=0xDEADBEEF... → mem_write=1 with address 0x100 and that data; mem_read=0 throughout; d_resp pulses exactly once; i_resp stays 0.
- i_read and d_read asserted together on the first cycle after reset → D served first (last_grant=I). With both held, I served next; the next tie goes to D, i.e. strict alternation over 4 transactions.
- I granted at 0x40, then i_address changed to 0x80 and d_read raised mid-transaction → mem_address stays 0x40 until i_resp; the D grant starts no earlier than 2 cycles after i_resp.
- rst=1 while in SERVE_D, then mem_resp pulsed 2 cycles later → mem_write=0 the cycle after reset; d_resp never asserts; busy=0.
- Stray mem_resp in IDLE, and d_read+d_write both high → no resp output for the stray pulse; the dual request issues mem_write only.

Source files
------------

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache and D-cache.
// Grants are latched in IDLE; mem_* are decoded from state and latched op only.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    state_t                  state, state_next;
    logic                    last_grant;   // 0 = I, 1 = D
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic                    write_q;
    logic                    d_pend, grant_d, grant_i;

    // On a tie the requester that did not win last time takes the port.
    assign d_pend  = d_read | d_write;
    assign grant_d = d_pend && (!i_read || !last_grant);
    assign grant_i = i_read && !grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (grant_d) begin
                    addr_q     <= d_address;
                    wdata_q    <= d_wdata;
                    write_q    <= d_write;
                    last_grant <= 1'b1;
                end else if (grant_i) begin
                    addr_q     <= i_address;
                    wdata_q    <= '0;
                    write_q    <= 1'b0;
                    last_grant <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d)      state_next = SERVE_D;
                else if (grant_i) state_next = SERVE_I;
            end
            SERVE_I: begin
                mem_read    = 1'b1;
                mem_address = addr_q;
                if (mem_resp) begin
                    i_resp     = 1'b1;
                    state_next = DONE;
                end
            end
            SERVE_D: begin
                mem_address = addr_q;
                if (write_q) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q;
                end else begin
                    mem_read = 1'b1;
                end
                if (mem_resp) begin
                    d_resp     = 1'b1;
                    state_next = DONE;
                end
            end
            // Bubble so a request still held after its resp is not granted twice.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Table-driven cycle vectors for cache_arbiter, plus a bounded hand-written handshake.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst, i_read, d_read, d_write, mem_resp;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] d_wdata, mem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_resp, d_resp, mem_read, mem_write, busy;
    logic [AW-1:0] mem_address;

    int checks = 0;
    int failures = 0;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, ir, dr, dw, mr;
        logic [AW-1:0] ia, da;
        logic [LW-1:0] dwd, mrd;
        logic          emr, emw, eir, edr, eb;
        logic [AW-1:0] ema;
        logic [LW-1:0] emwd;
    } vec_t;

    vec_t vq[$];

    localparam logic [LW-1:0] Z  = '0;
    localparam logic [LW-1:0] A5 = {32{8'hA5}};
    localparam logic [LW-1:0] DB = {8{32'hDEADBEEF}};
    localparam logic [LW-1:0] R1 = {8{32'h1111_2222}};
    localparam logic [LW-1:0] R2 = {8{32'h3333_4444}};

    task automatic add(input logic rst_v, ir, input logic [AW-1:0] ia,
                       input logic dr, dw, input logic [AW-1:0] da, input logic [LW-1:0] dwd,
                       input logic mr, input logic [LW-1:0] mrd,
                       input logic emr, emw, input logic [AW-1:0] ema, input logic [LW-1:0] emwd,
                       input logic eir, edr, eb);
        vec_t v;
        v.rst = rst_v; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.mr = mr; v.mrd = mrd; v.emr = emr; v.emw = emw; v.ema = ema; v.emwd = emwd;
        v.eir = eir; v.edr = edr; v.eb = eb;
        vq.push_back(v);
    endtask

    // No requests, no mem_resp; only busy is expected to vary.
    task automatic quiet(input logic eb);
        add(0, 0, 0, 0, 0, 0, Z, 0, Z, 0, 0, 0, Z, 0, 0, eb);
    endtask

    task automatic chk(input string nm, input int idx, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h exp=%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        int found, nir, ndr;
        rst = 1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;

        // I read at 0x40 with 3 wait cycles
        add(1, 0, 0, 0, 0, 0, Z, 0, Z, 0, 0, 0, Z, 0, 0, 0);
        add(0, 1, 'h40, 0, 0, 0, Z, 0, Z, 0, 0, 0, Z, 0, 0, 0);
        repeat (3) add(0, 1, 'h40, 0, 0, 0, Z, 0, Z, 1, 0, 'h40, Z, 0, 0, 1);
        add(0, 1, 'h40, 0, 0, 0, Z, 1, A5, 1, 0, 'h40, Z, 1, 0, 1);
        quiet(1);
        quiet(0);
        // D writeback to 0x100
        add(0, 0, 0, 0, 1, 'h100, DB, 0, Z, 0, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, 0, 1, 'h100, DB, 0, Z, 0, 1, 'h100, DB, 0, 0, 1);
        add(0, 0, 0, 0, 1, 'h100, DB, 1, A5, 0, 1, 'h100, DB, 0, 1, 1);
        quiet(1);
        quiet(0);
        // Tie after reset: D, I, D, I with both held
        add(1, 0, 0, 0, 0, 0, Z, 0, Z, 0, 0, 0, Z, 0, 0, 0);
        for (int t = 0; t < 4; t++) begin
            logic          gd;
            logic [AW-1:0] ga;
            gd = (t % 2 == 0);
            ga = gd ? 32'h200 : 32'h40;
            add(0, 1, 'h40, 1, 0, 'h200, Z, 0, Z, 0, 0, 0, Z, 0, 0, 0);
            add(0, 1, 'h40, 1, 0, 'h200, Z, 0, Z, 1, 0, ga, Z, 0, 0, 1);
            add(0, 1, 'h40, 1, 0, 'h200, Z, 1, gd ? R1 : R2, 1, 0, ga, Z, !gd, gd, 1);
            if (t < 3) add(0, 1, 'h40, 1, 0, 'h200, Z, 0, Z, 0, 0, 0, Z, 0, 0, 1);
        end
        quiet(1);
        quiet(0);
        // I at 0x40, address change and D request mid-transaction
        add(0, 1, 'h40, 0, 0, 0, Z, 0, Z, 0, 0, 0, Z, 0, 0, 0);
        add(0, 1, 'h80, 1, 0, 'h300, Z, 0, Z, 1, 0, 'h40, Z, 0, 0, 1);
        add(0, 1, 'h80, 1, 0, 'h300, Z, 0, Z, 1, 0, 'h40, Z, 0, 0, 1);
        add(0, 1, 'h80, 1, 0, 'h300, Z, 1, R1, 1, 0, 'h40, Z, 1, 0, 1);
        add(0, 0, 0, 1, 0, 'h300, Z, 0, Z, 0, 0, 0, Z, 0, 0, 1);
        add(0, 0, 0, 1, 0, 'h300, Z, 0, Z, 0, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, 1, 0, 'h300, Z, 0, Z, 1, 0, 'h300, Z, 0, 0, 1);
        // withdrawn request still completes
        add(0, 0, 0, 0, 0, 0, Z, 0, Z, 1, 0, 'h300, Z, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, Z, 1, R2, 1, 0, 'h300, Z, 0, 1, 1);
        quiet(1);
        quiet(0);
        // Reset during SERVE_D, then a late mem_resp
        add(0, 0, 0, 0, 1, 'h100, DB, 0, Z, 0, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, 0, 1, 'h100, DB, 0, Z, 0, 1, 'h100, DB, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, Z, 0, Z, 0, 1, 'h100, DB, 0, 0, 1);
        quiet(0);
        add(0, 0, 0, 0, 0, 0, Z, 1, A5, 0, 0, 0, Z, 0, 0, 0);
        quiet(0);
        // Stray mem_resp in IDLE, then read+write together -> write
        add(0, 0, 0, 0, 0, 0, Z, 1, A5, 0, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, 1, 1, 'h180, DB, 0, Z, 0, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, 1, 1, 'h180, DB, 0, Z, 0, 1, 'h180, DB, 0, 0, 1);
        add(0, 0, 0, 1, 1, 'h180, DB, 1, A5, 0, 1, 'h180, DB, 0, 1, 1);
        quiet(1);
        quiet(0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; i_read = vq[i].ir; i_address = vq[i].ia;
            d_read = vq[i].dr; d_write = vq[i].dw; d_address = vq[i].da; d_wdata = vq[i].dwd;
            mem_resp = vq[i].mr; mem_rdata = vq[i].mrd;
            #2;
            chk("mem_read", i, LW'(mem_read), LW'(vq[i].emr));
            chk("mem_write", i, LW'(mem_write), LW'(vq[i].emw));
            chk("mem_address", i, LW'(mem_address), LW'(vq[i].ema));
            chk("mem_wdata", i, mem_wdata, vq[i].emwd);
            chk("i_resp", i, LW'(i_resp), LW'(vq[i].eir));
            chk("d_resp", i, LW'(d_resp), LW'(vq[i].edr));
            chk("busy", i, LW'(busy), LW'(vq[i].eb));
            if (vq[i].eir) chk("i_rdata", i, i_rdata, vq[i].mrd);
            if (vq[i].edr) chk("d_rdata", i, d_rdata, vq[i].mrd);
        end

        // Bounded handshake: I read at 0x2C0, count resp pulses afterwards
        @(negedge clk);
        rst = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_read = 1; i_address = 32'h2C0;
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            @(posedge clk); #2;
            if (mem_read) found = 1;
        end
        chk("hs_grant", 999, LW'(found), LW'(1));
        chk("hs_addr", 999, LW'(mem_address), LW'(32'h2C0));
        @(negedge clk);
        mem_resp = 1; mem_rdata = R1;
        nir = 0; ndr = 0;
        #2;
        if (i_resp) nir++;
        if (d_resp) ndr++;
        chk("hs_rdata", 999, i_rdata, R1);
        @(negedge clk);
        mem_resp = 0; i_read = 0;
        repeat (4) begin
            #2;
            if (i_resp) nir++;
            if (d_resp) ndr++;
            @(negedge clk);
        end
        chk("hs_i_resp_count", 999, LW'(nir), LW'(1));
        chk("hs_d_resp_count", 999, LW'(ndr), LW'(0));
        chk("hs_idle", 999, LW'(busy), LW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
